// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker FSM state encoding, default geometry and the
// next-state function used by both the pattern generator and its checker.
package lfsr_pkg;

    localparam int unsigned LFSR_DEF_WIDTH = 4;
    localparam logic [3:0]  LFSR_DEF_TAPS  = 4'b1100;
    localparam int unsigned LFSR_MAX_W     = 32;

    typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SYNC    = 2'b01,
        ACQUIRE = 2'b10,
        LOCKED  = 2'b11
    } chk_state_t;

    // Shift left and insert the XOR of the tapped bits; bits above width are cleared.
    function automatic lfsr_word_t lfsr_next(input lfsr_word_t q,
                                             input lfsr_word_t taps,
                                             input int unsigned width);
        lfsr_word_t mask;
        logic       fb;
        if (width >= LFSR_MAX_W) mask = '1;
        else                     mask = (lfsr_word_t'(1) << width) - lfsr_word_t'(1);
        fb = ^(q & taps & mask);
        return ((q << 1) | lfsr_word_t'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Sample/control/status bundle between an LFSR source and lfsr_seq_checker.
// The signature field exists only when LFSR_CHK_MISR_EN is defined.
interface lfsr_seq_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNTW  = 16
);
    logic             enable;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             locked;
    logic             err_pulse;
    logic [CNTW-1:0]  err_count;
    logic [CNTW-1:0]  sample_count;
    logic [1:0]       state;
`ifdef LFSR_CHK_MISR_EN
    logic [WIDTH-1:0] signature;
`endif

    modport master (
        output enable, clear, in_valid, in_data,
`ifdef LFSR_CHK_MISR_EN
        input  signature,
`endif
        input  locked, err_pulse, err_count, sample_count, state
    );

    modport slave (
        input  enable, clear, in_valid, in_data,
`ifdef LFSR_CHK_MISR_EN
        output signature,
`endif
        output locked, err_pulse, err_count, sample_count, state
    );

endinterface

// File: rtl/lfsr_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)                       count_d = '0;
        else if (inc && count_q != '1) count_d = count_q + W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_seq_checker.sv
// LFSR sequence checker: self-seeds, locks after a run of matches, counts errors.
// Optional MISR signature over locked samples when LFSR_CHK_MISR_EN is defined.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH      = LFSR_DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_DEF_TAPS),
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      LOSS_COUNT = 3,
    parameter int unsigned      CNTW       = 16
) (
    input  logic               clock,
    input  logic               reset,
    lfsr_seq_checker_if.slave  bus
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] q);
        lfsr_word_t w;
        w = lfsr_next(lfsr_word_t'(q), lfsr_word_t'(TAPS), WIDTH);
        return w[WIDTH-1:0];
    endfunction

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_inc, sample_inc;
    logic             accept, match, zero;
    logic [CNTW-1:0]  err_count, sample_count;

    assign accept = bus.enable && bus.in_valid;
    assign match  = (bus.in_data == expected_q);
    assign zero   = (bus.in_data == '0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Next-state and prediction datapath
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_d      = run_q;
        miss_d     = miss_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    if (bus.in_valid && !zero) begin
                        expected_d = step(bus.in_data);
                        run_d      = '0;
                        state_d    = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (bus.in_valid) begin
                        if (match) begin
                            expected_d = step(expected_q);
                            run_d      = run_q + 4'd1;
                            if (run_d == LOCK_N) begin
                                state_d = LOCKED;
                                miss_d  = '0;
                            end
                        end else if (!zero) begin
                            expected_d = step(bus.in_data);
                            run_d      = '0;
                        end else begin
                            state_d = SYNC;
                        end
                    end
                end
                LOCKED: begin
                    // Once locked the prediction free-runs; bad samples never re-seed it.
                    if (bus.in_valid) begin
                        expected_d = step(expected_q);
                        if (match) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                            if (miss_d == LOSS_N) state_d = SYNC;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered status outputs and counter strobes
    always_comb begin
        sample_inc  = accept && (state_q == LOCKED);
        err_inc     = sample_inc && !match;
        err_pulse_d = err_inc;
        locked_d    = (state_d == LOCKED);
    end

    sat_counter #(.W(CNTW)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (err_inc),
        .clr   (bus.clear),
        .count (err_count)
    );

    sat_counter #(.W(CNTW)) u_sample_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (sample_inc),
        .clr   (bus.clear),
        .count (sample_count)
    );

`ifdef LFSR_CHK_MISR_EN
    logic [WIDTH-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (bus.clear)       sig_d = '0;
        else if (sample_inc) sig_d = step(sig_q) ^ bus.in_data;
    end

    always_ff @(posedge clock) begin
        if (reset) sig_q <= '0;
        else       sig_q <= sig_d;
    end

    assign bus.signature = sig_q;
`endif

    assign bus.state        = state_q;
    assign bus.locked       = locked_q;
    assign bus.err_pulse    = err_pulse_q;
    assign bus.err_count    = err_count;
    assign bus.sample_count = sample_count;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed self-checking bench for lfsr_seq_checker (default parameters).
// Covers the MISR signature as well when LFSR_CHK_MISR_EN is defined.
module tb_lfsr_seq_checker;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] seq [15];
    logic [3:0] sig_model;
    lfsr_word_t w;

    always #5 clk = ~clk;

    lfsr_seq_checker_if #(.WIDTH(4), .CNTW(16)) bus ();

    lfsr_seq_checker #(
        .WIDTH      (4),
        .TAPS       (4'b1100),
        .LOCK_COUNT (4),
        .LOSS_COUNT (3),
        .CNTW       (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
        rst = 1'b1;
        bus.enable = 1'b0; bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        cyc(0, 0); cyc(0, 0);
        rst = 1'b0;
        check("rst_state", 32'(bus.state), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_err_pulse", 32'(bus.err_pulse), 0);
        check("rst_err_count", 32'(bus.err_count), 0);
        check("rst_sample_count", 32'(bus.sample_count), 0);
`ifdef LFSR_CHK_MISR_EN
        check("rst_signature", 32'(bus.signature), 0);
`endif

        // Lock
        bus.enable = 1'b1;
        cyc(0, 0);      check("idle_to_sync", 32'(bus.state), 1);
        cyc(1, 4'hF);   check("seed_acquire", 32'(bus.state), 2);
        cyc(1, 4'hE); cyc(1, 4'hC); cyc(1, 4'h8);
        check("not_locked_yet", 32'(bus.locked), 0);
        cyc(1, 4'h1);
        check("lock_locked", 32'(bus.locked), 1);
        check("lock_state", 32'(bus.state), 3);
        check("lock_err_count", 32'(bus.err_count), 0);
        check("lock_sample_count", 32'(bus.sample_count), 0);

        // Single error while locked (expected 0010, send 0011)
        cyc(1, 4'h3);
        check("single_err_pulse", 32'(bus.err_pulse), 1);
        check("single_err_count", 32'(bus.err_count), 1);
        check("single_locked", 32'(bus.locked), 1);
        cyc(1, 4'h4);
        check("single_pulse_drop", 32'(bus.err_pulse), 0);
        check("single_err_hold", 32'(bus.err_count), 1);
        check("single_samples", 32'(bus.sample_count), 2);
        cyc(1, 4'h9);
        check("after_err_match", 32'(bus.err_count), 1);

        // Loss: clear counters, then three wrong samples (expected 0011)
        bus.clear = 1'b1; cyc(0, 0); bus.clear = 1'b0;
        check("clear_err_count", 32'(bus.err_count), 0);
        check("clear_sample_count", 32'(bus.sample_count), 0);
        cyc(1, 4'h0); cyc(1, 4'h0);
        check("loss_still_locked", 32'(bus.locked), 1);
        cyc(1, 4'h0);
        check("loss_err_count", 32'(bus.err_count), 3);
        check("loss_locked", 32'(bus.locked), 0);
        check("loss_state", 32'(bus.state), 1);
        check("loss_last_pulse", 32'(bus.err_pulse), 1);
        cyc(0, 0);
        check("loss_pulse_drop", 32'(bus.err_pulse), 0);

        // Zero seed rejected in SYNC
        cyc(1, 4'h0);   check("zero1_sync", 32'(bus.state), 1);
        cyc(1, 4'h0);   check("zero2_sync", 32'(bus.state), 1);
        cyc(1, 4'hF);   check("zero_then_seed", 32'(bus.state), 2);

        // Gapped lock: invalid cycles carry junk and must be ignored
        cyc(0, 4'h0); cyc(1, 4'hE);
        cyc(0, 4'h5); cyc(1, 4'hC);
        cyc(0, 4'h0); cyc(1, 4'h8);
        cyc(0, 4'h7);
        check("gap_not_locked", 32'(bus.locked), 0);
        check("gap_acquire", 32'(bus.state), 2);
        cyc(1, 4'h1);
        check("gap_locked", 32'(bus.locked), 1);

        // Clear together with a mismatch (expected 0010)
        bus.clear = 1'b1; cyc(1, 4'h5); bus.clear = 1'b0;
        check("clr_mis_err_count", 32'(bus.err_count), 0);
        check("clr_mis_pulse", 32'(bus.err_pulse), 1);
        check("clr_mis_samples", 32'(bus.sample_count), 0);
        cyc(1, 4'h4);
        check("clr_after_samples", 32'(bus.sample_count), 1);
        check("clr_after_err", 32'(bus.err_count), 0);

        // Enable low returns to IDLE, counters hold
        bus.enable = 1'b0; cyc(1, 4'h9);
        check("dis_state", 32'(bus.state), 0);
        check("dis_locked", 32'(bus.locked), 0);
        check("dis_samples_hold", 32'(bus.sample_count), 1);
        bus.enable = 1'b1; cyc(0, 0);

        // Reset mid-ACQUIRE
        cyc(1, 4'hF); cyc(1, 4'hE);
        check("pre_rst_acquire", 32'(bus.state), 2);
        rst = 1'b1; cyc(1, 4'hC); rst = 1'b0;
        check("mid_rst_state", 32'(bus.state), 0);
        check("mid_rst_locked", 32'(bus.locked), 0);
        check("mid_rst_samples", 32'(bus.sample_count), 0);
        check("mid_rst_err", 32'(bus.err_count), 0);
        check("mid_rst_pulse", 32'(bus.err_pulse), 0);

        // Full 15-sample locked pass
        cyc(0, 0);
        for (int i = 0; i < 5; i++) cyc(1, seq[i]);
        check("pass_locked", 32'(bus.locked), 1);
        sig_model = '0;
        for (int i = 0; i < 15; i++) begin
            cyc(1, seq[(i + 5) % 15]);
            w = lfsr_next(lfsr_word_t'(sig_model), lfsr_word_t'(4'b1100), 4);
            sig_model = w[3:0] ^ seq[(i + 5) % 15];
        end
        check("pass_samples", 32'(bus.sample_count), 15);
        check("pass_err_count", 32'(bus.err_count), 0);
        check("pass_still_locked", 32'(bus.locked), 1);
`ifdef LFSR_CHK_MISR_EN
        check("pass_signature", 32'(bus.signature), 32'(sig_model));
        bus.clear = 1'b1; cyc(0, 0); bus.clear = 1'b0;
        check("sig_clear", 32'(bus.signature), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
